// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 binary32 adder: IDLE -> ALIGN -> ADD -> NORM* -> ROUND -> DONE.
// Rounding mode is chosen at build time by FP_ADD_ROUND_NEAREST_EN (defined: nearest-even, else truncate).
module fp_add_sequencer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

`ifdef FP_ADD_ROUND_NEAREST_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  // Reset asserts asynchronously and releases two clk_i edges later.
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  state_t      state, state_nxt;
  logic [31:0] a_r, b_r, result_r;
  logic [26:0] big_r, sml_r;   // 24-bit significand + guard/round/sticky
  logic [27:0] sum_r;          // bit27 = carry, [26:3] significand, [2:0] GRS
  logic [8:0]  exp_r;
  logic        sign_r, sub_r;

  // Special-operand decode, evaluated on the raw inputs at transfer
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [31:0] special_val;
  always_comb begin
    a_nan  = (&a_i[30:23]) &&  (|a_i[22:0]);
    b_nan  = (&b_i[30:23]) &&  (|b_i[22:0]);
    a_inf  = (&a_i[30:23]) && !(|a_i[22:0]);
    b_inf  = (&b_i[30:23]) && !(|b_i[22:0]);
    a_zero = (a_i[30:23] == 8'd0);
    b_zero = (b_i[30:23] == 8'd0);
    special = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31])))
      special_val = 32'h7FC0_0000;
    else if (a_inf) special_val = {a_i[31], 8'hFF, 23'd0};
    else if (b_inf) special_val = {b_i[31], 8'hFF, 23'd0};
    else            special_val = {a_i[31] & b_i[31], 31'd0};
  end

  // Alignment: order by magnitude (exp-0 operands count as zero), shift the smaller
  logic [30:0] mag_a, mag_b;
  logic [31:0] big, sml;
  logic [23:0] big_sig, sml_sig;
  logic [7:0]  diff;
  logic [26:0] sml_ext, shifted, mask, aligned;
  always_comb begin
    mag_a   = (a_r[30:23] == 8'd0) ? 31'd0 : a_r[30:0];
    mag_b   = (b_r[30:23] == 8'd0) ? 31'd0 : b_r[30:0];
    big     = (mag_a >= mag_b) ? a_r : b_r;
    sml     = (mag_a >= mag_b) ? b_r : a_r;
    big_sig = (big[30:23] == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
    sml_sig = (sml[30:23] == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
    diff    = big[30:23] - sml[30:23];
    sml_ext = {sml_sig, 3'b000};
    shifted = sml_ext >> diff;
    mask    = (27'd1 << diff) - 27'd1;
    if (diff >= 8'd27) aligned = {26'd0, |sml_sig};
    else               aligned = {shifted[26:1], shifted[0] | (|(sml_ext & mask))};
  end

  logic [27:0] sum_calc;
  assign sum_calc = sub_r ? ({1'b0, big_r} - {1'b0, sml_r}) : ({1'b0, big_r} + {1'b0, sml_r});

  // Rounding on the normalized sum
  logic        inc;
  logic [24:0] rnd;
  logic [8:0]  rexp;
  logic [22:0] rman;
  logic [31:0] rres;
  always_comb begin
    inc  = RNE & sum_r[2] & (sum_r[1] | sum_r[0] | sum_r[3]);
    rnd  = {1'b0, sum_r[26:3]} + {24'd0, inc};
    rexp = rnd[24] ? exp_r + 9'd1 : exp_r;
    rman = rnd[24] ? rnd[23:1] : rnd[22:0];
    rres = (rexp >= 9'd255) ? {sign_r, 8'hFF, 23'd0} : {sign_r, rexp[7:0], rman};
  end

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (valid_i) state_nxt = special ? DONE : ALIGN;
      ALIGN: state_nxt = ADD;
      ADD:   state_nxt = (sum_calc == 28'd0) ? DONE : NORM;
      NORM:  if (sum_r[27] || sum_r[26]) state_nxt = ROUND;
             else if (exp_r == 9'd1)     state_nxt = DONE;
      ROUND: state_nxt = DONE;
      DONE:  if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0; b_r <= '0; result_r <= '0; big_r <= '0; sml_r <= '0;
      sum_r <= '0; exp_r <= '0; sign_r <= 1'b0; sub_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          a_r <= a_i;
          b_r <= b_i;
          if (special) result_r <= special_val;
        end
        ALIGN: begin
          big_r  <= {big_sig, 3'b000};
          sml_r  <= aligned;
          exp_r  <= {1'b0, big[30:23]};
          sign_r <= big[31];
          sub_r  <= big[31] ^ sml[31];
        end
        ADD: begin
          sum_r <= sum_calc;
          if (sum_calc == 28'd0) result_r <= 32'd0;
        end
        NORM:
          if (sum_r[27]) begin
            sum_r <= {1'b0, sum_r[27:2], sum_r[1] | sum_r[0]};
            exp_r <= exp_r + 9'd1;
          end else if (!sum_r[26]) begin
            if (exp_r == 9'd1) result_r <= {sign_r, 31'd0};
            else begin
              sum_r <= {sum_r[26:0], 1'b0};
              exp_r <= exp_r - 9'd1;
            end
          end
        ROUND: result_r <= rres;
        default: ;
      endcase
    end

  assign ready_o  = (state == IDLE);
  assign valid_o  = (state == DONE);
  assign busy_o   = (state != IDLE);
  assign result_o = result_r;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: vector table (result + latency) plus DONE-hold and mid-op reset sequences.
module tb_fp_add_sequencer;
  logic        clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic [31:0] a_i = '0, b_i = '0;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] result_o;

  int total = 0, bad = 0;

  fp_add_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a, b, res;
    int          lat;
  } vec_t;
  vec_t v[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle; returns result and latency (edges from transfer).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic rdy);
    a_i = a; b_i = b; valid_i = 1'b1;
    @(negedge clk_i); rdy = ready_o;
    @(posedge clk_i); #1; valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1; lat++;
    end
    res = result_o;
  endtask

  initial begin
    logic [31:0] res, held;
    int lat;
    logic rdy;

    v[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 5};
    v[1]  = '{32'h3FC00000, 32'hBFA00000, 32'h3E800000, 7};
    v[2]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 3};
    v[3]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1};
    v[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5};
`ifdef FP_ADD_ROUND_NEAREST_EN
    v[5]  = '{32'h3F800000, 32'h33C00000, 32'h3F800001, 5};
    v[6]  = '{32'h3F800001, 32'h33800000, 32'h3F800002, 5};
`else
    v[5]  = '{32'h3F800000, 32'h33C00000, 32'h3F800000, 5};
    v[6]  = '{32'h3F800001, 32'h33800000, 32'h3F800001, 5};
`endif
    v[7]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 5};
    v[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1};
    v[9]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1};
    v[10] = '{32'h80000000, 32'h80000000, 32'h80000000, 1};
    v[11] = '{32'h00000000, 32'h80000000, 32'h00000000, 1};
    v[12] = '{32'h40000000, 32'h3F800000, 32'h40400000, 5};
    v[13] = '{32'hC0400000, 32'h3F800000, 32'hC0000000, 5};
    v[14] = '{32'h00400000, 32'h3F800000, 32'h3F800000, 5};
    v[15] = '{32'h00800000, 32'h80800001, 32'h80000000, 4};
    v[16] = '{32'h3F800001, 32'hBF800000, 32'h34000000, 28};

    // Reset state
    #12;
    chk("rst ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst busy_o",  {31'd0, busy_o},  32'd0);
    chk("rst result_o", result_o, 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    for (int i = 0; i < 17; i++) begin
      do_op(v[i].a, v[i].b, res, lat, rdy);
      chk($sformatf("v%0d ready", i), {31'd0, rdy}, 32'd1);
      chk($sformatf("v%0d res", i), res, v[i].res);
      chk($sformatf("v%0d lat", i), lat, v[i].lat);
      @(posedge clk_i); #1;
    end

    // DONE hold with ready_i low; new operands must be ignored
    ready_i = 1'b0;
    do_op(32'h3F800000, 32'h3F800000, res, lat, rdy);
    chk("hold res", res, 32'h40000000);
    held = result_o;
    a_i = 32'h7F800000; b_i = 32'hFF800000; valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      chk($sformatf("hold%0d valid_o", k), {31'd0, valid_o}, 32'd1);
      chk($sformatf("hold%0d result_o", k), result_o, held);
      chk($sformatf("hold%0d ready_o", k), {31'd0, ready_o}, 32'd0);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("release valid_o", {31'd0, valid_o}, 32'd0);
    chk("release ready_o", {31'd0, ready_o}, 32'd1);

    // Reset pulse during NORM discards the operation
    a_i = 32'h3F800001; b_i = 32'hBF800000; valid_i = 1'b1;
    @(posedge clk_i); #1; valid_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    chk("pre-rst busy_o", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst ready_o", {31'd0, ready_o}, 32'd1);
    chk("midrst busy_o",  {31'd0, busy_o},  32'd0);
    chk("midrst result_o", result_o, 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk_i); #1;
      if (valid_o) begin
        chk("post-rst no valid_o", {31'd0, valid_o}, 32'd0);
        break;
      end
    end
    do_op(32'h40000000, 32'h3F800000, res, lat, rdy);
    chk("post-rst res", res, 32'h40400000);
    chk("post-rst lat", lat, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
